load_use_scoreboard: RTL and testbench

Issue-side counterpart of the EX-stage forwarding unit. It records each instruction's destination and result-readiness as it leaves ID, then tracks that record alongside EX/MEM/WB. When a source operand in ID would reach EX before its producer's result can be forwarded, it stalls ID/IF and injects a bubble. Typical case: a load followed by a dependent instruction.

---
 rtl/load_use_scoreboard.sv | 112 +++++++++++
 tb/tb_load_use_scoreboard.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - issue-side load-use hazard scoreboard with EX/MEM/WB shadow pipe
module load_use_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int MAX_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_Valid,
    input  logic [ADDR_W-1:0] ID_RsAddress,
    input  logic [ADDR_W-1:0] ID_RtAddress,
    input  logic              ID_RsUsed,
    input  logic              ID_RtUsed,
    input  logic [ADDR_W-1:0] ID_WBAddress,
    input  logic              ID_RegWriteEn,
    input  logic [1:0]        ID_Latency,
    input  logic              Flush,
    output logic              stall,
    output logic [1:0]        inflight,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] MaxRem = 2'(MAX_LAT);

    // Shadow pipe entries tracking each recorded writer alongside the real pipeline
    logic              exValid, memValid, wbValid;
    logic [ADDR_W-1:0] exDest, memDest, wbDest;
    logic [1:0]        exRem, memRem, wbRem;

    logic       hazardA, hazardB, accept;
    logic [1:0] newRem;

    // Remaining-latency countdown, floored at zero
    function automatic logic [1:0] decRem(input logic [1:0] r);
        return (r == 2'd0) ? 2'd0 : r - 2'd1;
    endfunction

    // Youngest matching writer decides; an older slow producer is shadowed by a newer ready one
    function automatic logic srcHazard(
        input logic              used,
        input logic [ADDR_W-1:0] addr,
        input logic              eV, input logic [ADDR_W-1:0] eD, input logic [1:0] eR,
        input logic              mV, input logic [ADDR_W-1:0] mD, input logic [1:0] mR,
        input logic              wV, input logic [ADDR_W-1:0] wD, input logic [1:0] wR
    );
        logic h;
        h = 1'b0;
        if (used && (addr != '0)) begin
            if (eV && (eD == addr)) begin
                h = (eR != 2'd0);
            end else if (mV && (mD == addr)) begin
                h = (mR != 2'd0);
            end else if (wV && (wD == addr)) begin
                h = (wR != 2'd0);
            end
        end
        return h;
    endfunction

    // Hazard detection, stall and accept decision for the instruction currently in ID
    always_comb begin
        hazardA = srcHazard(ID_RsUsed, ID_RsAddress,
                            exValid, exDest, exRem, memValid, memDest, memRem,
                            wbValid, wbDest, wbRem);
        hazardB = srcHazard(ID_RtUsed, ID_RtAddress,
                            exValid, exDest, exRem, memValid, memDest, memRem,
                            wbValid, wbDest, wbRem);
        stall   = ID_Valid & ~Flush & (hazardA | hazardB);
        accept  = ID_Valid & ID_RegWriteEn & (ID_WBAddress != '0) & ~stall & ~Flush;
        newRem  = (ID_Latency > MaxRem) ? MaxRem : ID_Latency;
    end

    // Shadow pipe advances every cycle; a stalled ID slot becomes a bubble in EX
    always_ff @(posedge clk) begin
        if (reset) begin
            exValid  <= 1'b0;
            exDest   <= '0;
            exRem    <= 2'd0;
            memValid <= 1'b0;
            memDest  <= '0;
            memRem   <= 2'd0;
            wbValid  <= 1'b0;
            wbDest   <= '0;
            wbRem    <= 2'd0;
        end else begin
            wbValid  <= memValid;
            wbDest   <= memDest;
            wbRem    <= decRem(memRem);
            memValid <= exValid;
            memDest  <= exDest;
            memRem   <= decRem(exRem);
            exValid  <= accept;
            exDest   <= accept ? ID_WBAddress : '0;
            exRem    <= accept ? newRem : 2'd0;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Occupancy of the shadow pipe, taken from registered state only
    always_comb begin
        inflight = {1'b0, exValid} + {1'b0, memValid} + {1'b0, wbValid};
    end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - self-checking bench for load_use_scoreboard
module tb_load_use_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_Valid;
    logic [4:0]  ID_RsAddress, ID_RtAddress, ID_WBAddress;
    logic        ID_RsUsed, ID_RtUsed, ID_RegWriteEn, Flush;
    logic [1:0]  ID_Latency;
    logic        stall;
    logic [1:0]  inflight;
    logic [15:0] stall_count;

    int nCmp = 0;
    int nErr = 0;

    load_use_scoreboard #(.ADDR_W(5), .MAX_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ID_Valid(ID_Valid),
        .ID_RsAddress(ID_RsAddress), .ID_RtAddress(ID_RtAddress),
        .ID_RsUsed(ID_RsUsed), .ID_RtUsed(ID_RtUsed),
        .ID_WBAddress(ID_WBAddress), .ID_RegWriteEn(ID_RegWriteEn),
        .ID_Latency(ID_Latency), .Flush(Flush),
        .stall(stall), .inflight(inflight), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, chk, valid;
        logic [4:0]  rs;
        logic        rsU;
        logic [4:0]  rt;
        logic        rtU;
        logic [4:0]  wb;
        logic        we;
        logic [1:0]  lat;
        logic        flush, eStall;
        logic [1:0]  eInfl;
        logic [15:0] eCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, chk, valid, input logic [4:0] rs, input logic rsU,
                                input logic [4:0] rt, input logic rtU, input logic [4:0] wb,
                                input logic we, input logic [1:0] lat, input logic flush,
                                input logic eStall, input logic [1:0] eInfl, input logic [15:0] eCnt);
        vec_t v;
        v.rst = rst; v.chk = chk; v.valid = valid; v.rs = rs; v.rsU = rsU; v.rt = rt; v.rtU = rtU;
        v.wb = wb; v.we = we; v.lat = lat; v.flush = flush;
        v.eStall = eStall; v.eInfl = eInfl; v.eCnt = eCnt;
        return v;
    endfunction

    function automatic vec_t idle(input logic [1:0] eInfl, input logic [15:0] eCnt);
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eInfl, eCnt);
    endfunction

    // Reference model: history of what was recorded 1, 2 and 3 cycles ago.
    // A writer recorded k cycles ago still needs max(lat-(k-1),0) cycles.
    logic       hV[1:3];
    logic [4:0] hD[1:3];
    int         hL[1:3];
    int         mCount;

    function automatic logic mHaz(input logic used, input logic [4:0] a);
        if (!used || a == 0) return 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (hV[k] && hD[k] == a) return (hL[k] > k - 1);
        end
        return 1'b0;
    endfunction

    function automatic logic mStall();
        return ID_Valid && !Flush && (mHaz(ID_RsUsed, ID_RsAddress) || mHaz(ID_RtUsed, ID_RtAddress));
    endfunction

    function automatic int mInfl();
        return int'(hV[1]) + int'(hV[2]) + int'(hV[3]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic advance();
        logic s, acc;
        s   = mStall();
        acc = ID_Valid && ID_RegWriteEn && ID_WBAddress != 0 && !s && !Flush;
        if (reset) begin
            for (int k = 1; k <= 3; k++) begin hV[k] = 0; hD[k] = 0; hL[k] = 0; end
            mCount = 0;
        end else begin
            hV[3] = hV[2]; hD[3] = hD[2]; hL[3] = hL[2];
            hV[2] = hV[1]; hD[2] = hD[1]; hL[2] = hL[1];
            hV[1] = acc;   hD[1] = ID_WBAddress;
            hL[1] = (int'(ID_Latency) > 2) ? 2 : int'(ID_Latency);
            if (s && mCount < 65535) mCount++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; ID_Valid = v.valid; ID_RsAddress = v.rs; ID_RsUsed = v.rsU;
        ID_RtAddress = v.rt; ID_RtUsed = v.rtU; ID_WBAddress = v.wb; ID_RegWriteEn = v.we;
        ID_Latency = v.lat; Flush = v.flush;
    endtask

    initial begin
        vec_t v;
        logic held;
        apply(idle(0, 0));
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin hV[k] = 0; hD[k] = 0; hL[k] = 0; end
        mCount = 0;

        //                rst chk val rs rsU rt rtU wb we lat fl  eS eI eC
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0));
        vecs.push_back(idle(0, 0));
        // load r5 then Rs=r5 consumer
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 1, 0, 0, 10, 1, 0, 0,  1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 5, 1, 0, 0, 10, 1, 0, 0,  0, 1, 1));
        vecs.push_back(idle(2, 1)); vecs.push_back(idle(1, 1)); vecs.push_back(idle(1, 1));
        // ALU r5 then Rt=r5 consumer
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 5, 1, 11, 1, 0, 0,  0, 1, 1));
        vecs.push_back(idle(2, 1)); vecs.push_back(idle(2, 1)); vecs.push_back(idle(1, 1));
        // long op r7 (lat 2), then lat 3 clamped
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 7, 1, 2, 0,   0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,   1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,   1, 1, 2));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,   0, 1, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 7, 1, 3, 0,   0, 0, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0,   1, 1, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0,   1, 1, 4));
        vecs.push_back(mk(0, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, 5));
        // slow r3 shadowed by younger ALU r3
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 1, 2, 0,   0, 0, 5));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0,   0, 1, 5));
        vecs.push_back(mk(0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0,   0, 2, 5));
        vecs.push_back(idle(2, 5)); vecs.push_back(idle(1, 5));
        // r0 never recorded or matched; unused source ignored
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 5));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 5));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0,   0, 0, 5));
        vecs.push_back(mk(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0,   0, 1, 5));
        vecs.push_back(idle(1, 5)); vecs.push_back(idle(1, 5));
        // flush in the would-be stall cycle
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 6, 1, 1, 0,   0, 0, 5));
        vecs.push_back(mk(0, 1, 1, 6, 1, 0, 0, 12, 1, 0, 1,  0, 1, 5));
        vecs.push_back(idle(1, 5)); vecs.push_back(idle(1, 5)); vecs.push_back(idle(0, 5));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d stall", i), int'(stall), int'(vecs[i].eStall));
                check($sformatf("vec%0d inflight", i), int'(inflight), int'(vecs[i].eInfl));
                check($sformatf("vec%0d stall_count", i), int'(stall_count), int'(vecs[i].eCnt));
            end
            advance();
        end

        // Reset asserted while a consumer is stalled on a long op
        apply(mk(0, 1, 1, 0, 0, 0, 0, 9, 1, 2, 0, 0, 0, 0));
        @(negedge clk); advance();
        apply(mk(0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_mid pre stall", int'(stall), 1);
        advance();
        reset = 1'b1;
        @(negedge clk);
        advance();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid stall", int'(stall), 0);
        check("rst_mid inflight", int'(inflight), 0);
        check("rst_mid stall_count", int'(stall_count), 0);
        advance();

        // Randomized run against the history model; ID holds steady while stalled
        reset = 1'b1;
        @(negedge clk); advance();
        reset = 1'b0;
        held = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!held) begin
                ID_Valid      = ($urandom_range(0, 9) != 0);
                ID_RsAddress  = 5'($urandom_range(0, 7));
                ID_RtAddress  = 5'($urandom_range(0, 7));
                ID_RsUsed     = 1'($urandom);
                ID_RtUsed     = 1'($urandom);
                ID_WBAddress  = 5'($urandom_range(0, 7));
                ID_RegWriteEn = ($urandom_range(0, 3) != 0);
                ID_Latency    = 2'($urandom);
            end
            Flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            check("rand stall", int'(stall), int'(mStall()));
            check("rand inflight", int'(inflight), mInfl());
            check("rand stall_count", int'(stall_count), mCount);
            held = stall && !reset;
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
